ex_result_writeback: RTL and testbench

Consumer of the EX-stage ALU outputs. Registers ALU_Result, Remainder and Overflow_flag into a single-write-port register-file interface, serialising the two-result MUL/DIV ops over two cycles with a back-pressure ready. Turns ADD/SUB overflow into a suppressed write plus an exception pulse. Sits between the ALU and the register file, as the EX/WB boundary.

---
 rtl/alu_ops_pkg.sv | 30 +++
 rtl/ex_result_writeback.sv | 98 +++++++++
 tb/tb_ex_result_writeback.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/alu_ops_pkg.sv
// ALU control codes and EX/WB writeback state, shared by the ALU and the
// result writeback stage.
package alu_ops_pkg;

    localparam logic [3:0] CTRL_ADD = 4'b1111;
    localparam logic [3:0] CTRL_SUB = 4'b1110;
    localparam logic [3:0] CTRL_AND = 4'b1101;
    localparam logic [3:0] CTRL_OR  = 4'b1100;
    localparam logic [3:0] CTRL_SLL = 4'b1010;
    localparam logic [3:0] CTRL_SRL = 4'b1011;
    localparam logic [3:0] CTRL_ROL = 4'b1000;
    localparam logic [3:0] CTRL_ROR = 4'b1001;
    localparam logic [3:0] CTRL_MUL = 4'b0001;
    localparam logic [3:0] CTRL_DIV = 4'b0010;
    localparam logic [3:0] CTRL_NOP = 4'b0000;

    localparam logic [7:0] OVF_COUNT_MAX = 8'd255;

    typedef enum logic {
        IDLE,
        WR2
    } wb_state_t;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_SINGLE,
        OP_DUAL
    } op_class_t;

endpackage

// File: rtl/ex_result_writeback.sv
// EX/WB boundary: registers ALU results into a single-port register file,
// serialising MUL/DIV into two writes and turning ADD/SUB overflow into an exception.
module ex_result_writeback
    import alu_ops_pkg::*;
#(
    parameter logic [3:0] REM_REG = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  logic [3:0]  ex_ctrl,
    input  logic [3:0]  ex_dest,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_remainder,
    input  logic        ex_overflow,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic        ovf_exc,
    output logic [3:0]  ovf_dest,
    output logic [7:0]  ovf_count
);

    function automatic op_class_t op_class(input logic [3:0] ctrl);
        case (ctrl)
            CTRL_ADD, CTRL_SUB, CTRL_AND, CTRL_OR,
            CTRL_SLL, CTRL_SRL, CTRL_ROL, CTRL_ROR: op_class = OP_SINGLE;
            CTRL_MUL, CTRL_DIV:                     op_class = OP_DUAL;
            default:                                op_class = OP_NONE;
        endcase
    endfunction

    wb_state_t   state;
    logic [15:0] rem_hold;
    logic        accept;
    logic        ovf_trap;
    op_class_t   cls;

    assign ex_ready = (state == IDLE);
    assign accept   = ex_valid && ex_ready;
    assign cls      = op_class(ex_ctrl);
    // Overflow is only meaningful for the add/subtract datapath.
    assign ovf_trap = ex_overflow && ((ex_ctrl == CTRL_ADD) || (ex_ctrl == CTRL_SUB));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rem_hold  <= 16'd0;
            rf_we     <= 1'b0;
            rf_waddr  <= 4'd0;
            rf_wdata  <= 16'd0;
            ovf_exc   <= 1'b0;
            ovf_dest  <= 4'd0;
            ovf_count <= 8'd0;
        end else begin
            rf_we   <= 1'b0;
            ovf_exc <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        case (cls)
                            OP_SINGLE: begin
                                if (ovf_trap) begin
                                    ovf_exc  <= 1'b1;
                                    ovf_dest <= ex_dest;
                                    if (ovf_count != OVF_COUNT_MAX)
                                        ovf_count <= ovf_count + 8'd1;
                                end else begin
                                    rf_we    <= 1'b1;
                                    rf_waddr <= ex_dest;
                                    rf_wdata <= ex_result;
                                end
                            end
                            OP_DUAL: begin
                                rf_we    <= 1'b1;
                                rf_waddr <= ex_dest;
                                rf_wdata <= ex_result;
                                rem_hold <= ex_remainder;
                                state    <= WR2;
                            end
                            default: ;
                        endcase
                    end
                end
                WR2: begin
                    // Second write lands after the result, so it wins if REM_REG == dest.
                    rf_we    <= 1'b1;
                    rf_waddr <= REM_REG;
                    rf_wdata <= rem_hold;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_result_writeback.sv
// Directed bench for ex_result_writeback: expected register-file writes are
// queued as ops are driven and checked in order as rf_we fires.
module tb_ex_result_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_ctrl;
    logic [3:0]  ex_dest;
    logic [15:0] ex_result;
    logic [15:0] ex_remainder;
    logic        ex_overflow;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        ovf_exc;
    logic [3:0]  ovf_dest;
    logic [7:0]  ovf_count;

    int n_assert = 0;
    int n_fail   = 0;
    logic [19:0] exp_q[$];

    ex_result_writeback #(.REM_REG(4'd0)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_ctrl(ex_ctrl), .ex_dest(ex_dest),
        .ex_result(ex_result), .ex_remainder(ex_remainder),
        .ex_overflow(ex_overflow),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .ovf_exc(ovf_exc), .ovf_dest(ovf_dest), .ovf_count(ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [3:0] d,
                         input logic [15:0] r, input logic [15:0] m, input logic o);
        ex_valid = v; ex_ctrl = c; ex_dest = d; ex_result = r; ex_remainder = m; ex_overflow = o;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] a, input logic [15:0] d);
        exp_q.push_back({a, d});
    endtask

    // Scoreboard: every write must match the next queued expectation.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {12'd0, rf_waddr, rf_wdata}, 32'hFFFF_FFFF);
            end else begin
                logic [19:0] e;
                e = exp_q.pop_front();
                chk("sb_write", {12'd0, rf_waddr, rf_wdata}, {12'd0, e});
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick(); tick();
        chk("rst_we", rf_we, 0);
        chk("rst_waddr", rf_waddr, 0);
        chk("rst_wdata", rf_wdata, 0);
        chk("rst_ovf_exc", ovf_exc, 0);
        chk("rst_ovf_dest", ovf_dest, 0);
        chk("rst_ovf_count", ovf_count, 0);
        chk("rst_ready", ex_ready, 1);
        rst = 1'b0;

        // ADD single write, visible for exactly one cycle
        drive(1'b1, 4'hF, 4'd3, 16'h0005, 16'h0, 1'b0); push(4'd3, 16'h0005);
        tick();
        chk("add_we", rf_we, 1);
        chk("add_waddr", rf_waddr, 3);
        chk("add_wdata", rf_wdata, 16'h0005);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("add_we_off", rf_we, 0);

        // MUL two writes, with a held op behind it
        drive(1'b1, 4'h1, 4'd5, 16'h0000, 16'h0001, 1'b0); push(4'd5, 16'h0000); push(4'd0, 16'h0001);
        tick();
        chk("mul_ready", ex_ready, 0);
        chk("mul_w1_we", rf_we, 1);
        chk("mul_w1_addr", rf_waddr, 5);
        chk("mul_w1_data", rf_wdata, 16'h0000);
        drive(1'b1, 4'hF, 4'd9, 16'h1234, 16'h0, 1'b0);
        tick();
        chk("mul_w2_we", rf_we, 1);
        chk("mul_w2_addr", rf_waddr, 0);
        chk("mul_w2_data", rf_wdata, 16'h0001);
        chk("mul_ready_back", ex_ready, 1);
        push(4'd9, 16'h1234);
        tick();
        chk("held_addr", rf_waddr, 9);
        chk("held_data", rf_wdata, 16'h1234);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();

        // SUB overflow: suppressed write, exception pulse
        drive(1'b1, 4'hE, 4'd7, 16'hBEEF, 16'h0, 1'b1);
        tick();
        chk("ovf_we", rf_we, 0);
        chk("ovf_exc", ovf_exc, 1);
        chk("ovf_dest", ovf_dest, 7);
        chk("ovf_count1", ovf_count, 1);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("ovf_exc_pulse", ovf_exc, 0);
        chk("ovf_dest_hold", ovf_dest, 7);

        // 256 more overflows saturate the counter
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, (i[0] ? 4'hE : 4'hF), 4'd7, 16'h0, 16'h0, 1'b1);
            tick();
            if (i == 252) chk("ovf_count254", ovf_count, 254);
        end
        chk("ovf_count_sat_exc", ovf_exc, 1);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("ovf_count_sat", ovf_count, 255);

        // DIV with dest == REM_REG: remainder ends up last
        drive(1'b1, 4'h2, 4'd0, 16'h0003, 16'h0001, 1'b0); push(4'd0, 16'h0003); push(4'd0, 16'h0001);
        tick();
        chk("div_w1_data", rf_wdata, 16'h0003);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();
        chk("div_w2_addr", rf_waddr, 0);
        chk("div_w2_data", rf_wdata, 16'h0001);
        tick();

        // Reset during WR2 drops the remainder write
        drive(1'b1, 4'h2, 4'd4, 16'h00AA, 16'h0055, 1'b0); push(4'd4, 16'h00AA);
        tick();
        chk("divr_w1_we", rf_we, 1);
        chk("divr_ready", ex_ready, 0);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        rst = 1'b1;
        tick();
        chk("divr_we", rf_we, 0);
        chk("divr_waddr", rf_waddr, 0);
        chk("divr_wdata", rf_wdata, 0);
        chk("divr_ovf_count", ovf_count, 0);
        chk("divr_ovf_dest", ovf_dest, 0);
        chk("divr_ready", ex_ready, 1);

        // Reset wins over a simultaneous accept
        drive(1'b1, 4'hF, 4'd6, 16'h7777, 16'h0, 1'b0);
        tick();
        chk("rst_prio_we", rf_we, 0);
        rst = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick();

        // OR, AND with stray overflow, then NOP
        drive(1'b1, 4'hC, 4'd1, 16'h00F0, 16'h0, 1'b0); push(4'd1, 16'h00F0);
        tick();
        chk("or_we", rf_we, 1);
        chk("or_addr", rf_waddr, 1);
        drive(1'b1, 4'hD, 4'd2, 16'h000F, 16'h0, 1'b1); push(4'd2, 16'h000F);
        tick();
        chk("and_we", rf_we, 1);
        chk("and_addr", rf_waddr, 2);
        chk("and_exc", ovf_exc, 0);
        drive(1'b1, 4'h0, 4'd3, 16'hDEAD, 16'h0, 1'b1);
        tick();
        chk("nop_we", rf_we, 0);
        chk("nop_exc", ovf_exc, 0);
        drive(1'b0, 4'h0, 4'h0, 16'h0, 16'h0, 1'b0);
        tick(); tick();

        chk("sb_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
